// File: rtl/instr_fetch_decoder.sv
// Instruction-fetch / pre-decode stage for a WebAssembly core.
// Pulls a byte window from instruction memory, decodes one opcode plus its
// LEB128 immediate, hands it to execute over valid/ready, and returns the
// consumed length so the memory read pointer advances by one instruction.
// Optional feature macro: MEMARG_EN (load/store memarg decode + align port).
module instr_fetch_decoder #(
   parameter int WINDOW_BYTES = 8,
   parameter int LOG_WINDOW   = 3,
   parameter int IMM_WIDTH    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      re,
   input  logic [8*WINDOW_BYTES-1:0] rd_data,
   input  logic                      rd_data_vld,
   input  logic                      instr_finish,
   output logic                      shift_vld,
   output logic [LOG_WINDOW:0]       read_pointer_shift_minusone,
   output logic                      instr_vld,
   input  logic                      instr_rdy,
   output logic [7:0]                opcode,
   output logic [IMM_WIDTH-1:0]      imm,
   output logic                      imm_vld,
   output logic [3:0]                instr_len,
   output logic                      dec_err,
`ifdef MEMARG_EN
   output logic [7:0]                align,
`endif
   output logic                      done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_ERR} state_t;
   typedef enum logic [2:0] {K_NONE, K_ULEB, K_SLEB, K_RAW, K_MEMARG} kind_t;

   state_t               r_state, w_state_nxt;
   kind_t                w_kind;
   logic [7:0]           w_byte [0:7];
   logic [2:0]           w_leb_start;
   logic [2:0]           w_idx;
   logic [IMM_WIDTH-1:0] w_leb_val;
   logic [2:0]           w_leb_len;
   logic                 w_leb_end;
   int unsigned          w_sext_pos;
   logic [IMM_WIDTH-1:0] w_imm;
   logic                 w_imm_vld;
   logic [3:0]           w_len;
   logic                 w_err;
   logic [7:0]           r_opcode;
   logic [IMM_WIDTH-1:0] r_imm;
   logic                 r_imm_vld;
   logic [3:0]           r_len;
`ifdef MEMARG_EN
   logic [7:0]           w_align;
   logic [7:0]           r_align;
`endif

   // Split the first eight window bytes; byte 0 sits at the read pointer.
   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         w_byte[i] = rd_data[8*i +: 8];
      end
   end

   // Classify the opcode byte by the kind of immediate it carries.
   always_comb begin
      w_kind = K_NONE;
      case (w_byte[0])
         8'h0c, 8'h0d, 8'h10,
         8'h20, 8'h21, 8'h22, 8'h23, 8'h24: w_kind = K_ULEB;
         8'h41:                             w_kind = K_SLEB;
         8'h02, 8'h03, 8'h04:               w_kind = K_RAW;
         default: begin
`ifdef MEMARG_EN
            if (w_byte[0] >= 8'h28 && w_byte[0] <= 8'h3e) w_kind = K_MEMARG;
`endif
         end
      endcase
   end

   // LEB128 decode (max 5 bytes); bits past IMM_WIDTH fall off the shift.
   always_comb begin
      w_leb_start = (w_kind == K_MEMARG) ? 3'd2 : 3'd1;
      w_leb_val   = '0;
      w_leb_len   = '0;
      w_leb_end   = 1'b0;
      w_idx       = '0;
      for (int unsigned n = 0; n < 5; n++) begin
         if (!w_leb_end) begin
            w_idx     = 3'(w_leb_start + n);
            w_leb_val = w_leb_val | (IMM_WIDTH'(w_byte[w_idx][6:0]) << (7 * n));
            if (!w_byte[w_idx][7]) begin
               w_leb_end = 1'b1;
               w_leb_len = 3'(n + 1);
            end
         end
      end
      // sign bit beyond IMM_WIDTH was already discarded, so no extension then
      w_sext_pos = 7 * {29'd0, w_leb_len};
      if (w_kind == K_SLEB && w_leb_end && w_sext_pos <= IMM_WIDTH) begin
         if (w_leb_val[w_sext_pos-1]) w_leb_val = w_leb_val | ({IMM_WIDTH{1'b1}} << w_sext_pos);
      end
   end

   // Assemble decoded fields and the malformed-encoding flag.
   always_comb begin
      w_imm     = '0;
      w_imm_vld = 1'b0;
      w_len     = 4'd1;
      w_err     = 1'b0;
`ifdef MEMARG_EN
      w_align   = '0;
`endif
      case (w_kind)
         K_ULEB, K_SLEB: begin
            w_imm     = w_leb_val;
            w_imm_vld = 1'b1;
            w_len     = 4'd1 + {1'b0, w_leb_len};
            w_err     = !w_leb_end;
         end
         K_RAW: begin
            w_imm     = IMM_WIDTH'(w_byte[1]);
            w_imm_vld = 1'b1;
            w_len     = 4'd2;
         end
         K_MEMARG: begin
`ifdef MEMARG_EN
            w_align   = w_byte[1];
`endif
            w_imm     = w_leb_val;
            w_imm_vld = 1'b1;
            w_len     = 4'd2 + {1'b0, w_leb_len};
            w_err     = w_byte[1][7] || !w_leb_end;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs; reset suppresses a same-cycle shift.
   always_comb begin
      w_state_nxt = r_state;
      re          = 1'b0;
      instr_vld   = 1'b0;
      shift_vld   = 1'b0;
      done        = 1'b0;
      dec_err     = 1'b0;
      case (r_state)
         S_IDLE: begin
            done = instr_finish && !rst;
            if (!instr_finish) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            re = 1'b1;
            if (rd_data_vld) w_state_nxt = w_err ? S_ERR : S_OUT;
         end
         S_OUT: begin
            instr_vld = 1'b1;
            if (instr_rdy) begin
               shift_vld   = !rst;
               w_state_nxt = S_IDLE;
            end
         end
         S_ERR:   dec_err = 1'b1;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture decoded instruction at the end of a successful fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode  <= '0;
         r_imm     <= '0;
         r_imm_vld <= 1'b0;
         r_len     <= '0;
`ifdef MEMARG_EN
         r_align   <= '0;
`endif
      end else if (r_state == S_FETCH && rd_data_vld && !w_err) begin
         r_opcode  <= w_byte[0];
         r_imm     <= w_imm;
         r_imm_vld <= w_imm_vld;
         r_len     <= w_len;
`ifdef MEMARG_EN
         r_align   <= w_align;
`endif
      end
   end

   assign opcode    = r_opcode;
   assign imm       = r_imm;
   assign imm_vld   = r_imm_vld;
   assign instr_len = r_len;
`ifdef MEMARG_EN
   assign align     = r_align;
`endif
   assign read_pointer_shift_minusone = shift_vld ? (LOG_WINDOW+1)'(r_len - 4'd1) : '0;

endmodule

// File: tb/tb_instr_fetch_decoder.sv
// Self-checking bench for instr_fetch_decoder (scoreboard of expected
// instructions, directed stimulus). Build with +define+MEMARG_EN to cover
// the memarg decode as well.
module tb_instr_fetch_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        re;
   logic [63:0] rd_data;
   logic        rd_data_vld;
   logic        instr_finish;
   logic        shift_vld;
   logic [3:0]  read_pointer_shift_minusone;
   logic        instr_vld;
   logic        instr_rdy;
   logic [7:0]  opcode;
   logic [31:0] imm;
   logic        imm_vld;
   logic [3:0]  instr_len;
   logic        dec_err;
   logic        done;
`ifdef MEMARG_EN
   logic [7:0]  align;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] im;
      logic        iv;
      logic [3:0]  len;
      logic [7:0]  al;
   } exp_t;

   exp_t sb[$];

   instr_fetch_decoder #(.WINDOW_BYTES(8), .LOG_WINDOW(3), .IMM_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .re(re), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
      .instr_finish(instr_finish), .shift_vld(shift_vld),
      .read_pointer_shift_minusone(read_pointer_shift_minusone),
      .instr_vld(instr_vld), .instr_rdy(instr_rdy), .opcode(opcode), .imm(imm),
      .imm_vld(imm_vld), .instr_len(instr_len), .dec_err(dec_err),
`ifdef MEMARG_EN
      .align(align),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input logic [63:0] w, input logic [7:0] op, input logic [31:0] im,
                               input logic iv, input logic [3:0] len, input logic [7:0] al);
      exp_t e;
      e.op = op; e.im = im; e.iv = iv; e.len = len; e.al = al;
      sb.push_back(e);
      rd_data     = w;
      rd_data_vld = 1'b1;
   endtask

   // mode 0: normal handshake, 1: instr_finish raised while held, 2: reset while held
   task automatic collect(input string tag, input int hold, input int mode);
      exp_t        e;
      int unsigned n;
      logic        prev_re;
      logic        seen;
      n = 0; prev_re = 1'b0; seen = 1'b0;
      instr_rdy = 1'b0;
      while (!seen && n < 20) begin
         if (instr_vld === 1'b1) seen = 1'b1;
         else begin
            prev_re = re;
            step();
            n++;
         end
      end
      chk({tag, "_vld_timeout"}, 64'(seen), 64'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      if (!seen) return;
      chk({tag, "_fetch_latency"}, 64'(prev_re), 64'd1);
      chk({tag, "_cycles"}, 64'(n), 64'd2);
      for (int h = 0; h <= hold; h++) begin
         chk({tag, "_opcode"}, 64'(opcode), 64'(e.op));
         chk({tag, "_imm"}, 64'(imm), 64'(e.im));
         chk({tag, "_imm_vld"}, 64'(imm_vld), 64'(e.iv));
         chk({tag, "_len"}, 64'(instr_len), 64'(e.len));
`ifdef MEMARG_EN
         chk({tag, "_align"}, 64'(align), 64'(e.al));
`endif
         if (h < hold) begin
            chk({tag, "_hold_vld"}, 64'(instr_vld), 64'd1);
            chk({tag, "_hold_noshift"}, 64'(shift_vld), 64'd0);
            step();
         end
      end
      if (mode == 1) instr_finish = 1'b1;
      if (mode == 2) rst = 1'b1;
      instr_rdy = 1'b1;
      #1;
      if (mode == 2) begin
         chk({tag, "_rst_noshift"}, 64'(shift_vld), 64'd0);
      end else begin
         chk({tag, "_shift_vld"}, 64'(shift_vld), 64'd1);
         chk({tag, "_minusone"}, 64'(read_pointer_shift_minusone), 64'(e.len - 4'd1));
      end
      step();
      instr_rdy = 1'b0;
      rst       = 1'b0;
      #1;
      chk({tag, "_post_shift"}, 64'(shift_vld), 64'd0);
      chk({tag, "_post_vld"}, 64'(instr_vld), 64'd0);
      if (mode == 1) chk({tag, "_done"}, 64'(done), 64'd1);
   endtask

   initial begin
      rst = 1'b1; rd_data = '0; rd_data_vld = 1'b0; instr_finish = 1'b0; instr_rdy = 1'b0;
      step();
      step();
      chk("rst_re", 64'(re), 64'd0);
      chk("rst_shift", 64'(shift_vld), 64'd0);
      chk("rst_minusone", 64'(read_pointer_shift_minusone), 64'd0);
      chk("rst_vld", 64'(instr_vld), 64'd0);
      chk("rst_opcode", 64'(opcode), 64'd0);
      chk("rst_imm", 64'(imm), 64'd0);
      chk("rst_imm_vld", 64'(imm_vld), 64'd0);
      chk("rst_len", 64'(instr_len), 64'd0);
      chk("rst_dec_err", 64'(dec_err), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      instr_finish = 1'b1;
      #1;
      chk("rst_done_fin", 64'(done), 64'd0);
      rst = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("fin_done", 64'(done), 64'd1);
         chk("fin_no_re", 64'(re), 64'd0);
         step();
      end
      instr_finish = 1'b0;

      // i32.const 221 (41 dd 01)
      expect_instr(64'hffff_ffff_ff01_dd41, 8'h41, 32'h0000_00dd, 1'b1, 4'd3, 8'h00);
      collect("sleb_221", 0, 0);
      // i32.const -1 (41 7f)
      expect_instr(64'hffff_ffff_ffff_7f41, 8'h41, 32'hffff_ffff, 1'b1, 4'd2, 8'h00);
      collect("sleb_m1", 0, 0);
      // local.get 1 (20 01)
      expect_instr(64'hffff_ffff_ffff_0120, 8'h20, 32'h0000_0001, 1'b1, 4'd2, 8'h00);
      collect("local_get", 0, 0);
      // block with blocktype 0x40
      expect_instr(64'hffff_ffff_ffff_4002, 8'h02, 32'h0000_0040, 1'b1, 4'd2, 8'h00);
      collect("block_raw", 0, 0);
      // call 624485 (10 e5 8e 26)
      expect_instr(64'hffff_ffff_268e_e510, 8'h10, 32'h0009_8765, 1'b1, 4'd4, 8'h00);
      collect("call_uleb", 0, 0);
      // 5-byte signed LEB; top bits fall off the 32-bit result
      expect_instr(64'hffff_7f80_8080_8041, 8'h41, 32'hf000_0000, 1'b1, 4'd6, 8'h00);
      collect("sleb_5byte", 0, 0);
      // 5-byte unsigned max (0d ff ff ff ff 0f)
      expect_instr(64'hffff_0fff_ffff_ff0d, 8'h0d, 32'hffff_ffff, 1'b1, 4'd6, 8'h00);
      collect("uleb_max", 0, 0);
      // no-immediate opcode held 5 cycles with rdy low
      expect_instr(64'hffff_ffff_ffff_ff6b, 8'h6b, 32'h0, 1'b0, 4'd1, 8'h00);
      collect("hold_6b", 5, 0);
`ifdef MEMARG_EN
      expect_instr(64'hffff_ffff_ff10_0228, 8'h28, 32'h0000_0010, 1'b1, 4'd3, 8'h02);
      collect("memarg", 0, 0);
`else
      expect_instr(64'hffff_ffff_ff10_0228, 8'h28, 32'h0, 1'b0, 4'd1, 8'h00);
      collect("memarg_off", 0, 0);
`endif
      // reset while instruction held: discarded, no shift
      expect_instr(64'hffff_ffff_ffff_ff6a, 8'h6a, 32'h0, 1'b0, 4'd1, 8'h00);
      collect("rst_out", 1, 2);
      // instr_finish while held: still delivered, then done
      expect_instr(64'hffff_ffff_ffff_ff01, 8'h01, 32'h0, 1'b0, 4'd1, 8'h00);
      collect("fin_out", 0, 1);
      step();
      chk("fin_out_done2", 64'(done), 64'd1);
      chk("fin_out_no_re", 64'(re), 64'd0);
      instr_finish = 1'b0;

      // overlong LEB: 20 80 80 80 80 80
      rd_data = 64'hffff_8080_8080_8020;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("err_no_vld", 64'(instr_vld), 64'd0);
         chk("err_no_shift", 64'(shift_vld), 64'd0);
      end
      instr_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("err_sticky", 64'(dec_err), 64'd1);
         chk("err_no_re", 64'(re), 64'd0);
         step();
      end
      instr_rdy = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("err_cleared", 64'(dec_err), 64'd0);
`ifdef MEMARG_EN
      rd_data = 64'hffff_ffff_ff10_8228;
      step();
      step();
      step();
      chk("memarg_align_err", 64'(dec_err), 64'd1);
      chk("memarg_align_novld", 64'(instr_vld), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
`endif
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decoder.md
Name: instr_fetch_decoder

Overview:
- Instruction-fetch/pre-decode stage directly downstream of the instruction memory controller.
- Requests a byte window, extracts one WebAssembly opcode plus its LEB128 immediate(s), and presents the decoded instruction to the execute stage with a valid/ready handshake.
- Returns the consumed byte count to the memory controller as a shift request so the read pointer advances by exactly one instruction.

Parameters:
- WINDOW_BYTES, 8, bytes per read window; must be at least 8.
- LOG_WINDOW, 3, log2(WINDOW_BYTES).
- IMM_WIDTH, 32, decoded immediate width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- re  output  1  read request to instruction memory; read data is combinational in the same cycle.
- rd_data  input  8*WINDOW_BYTES  byte window; byte k is at [8k+:8], byte 0 = current read pointer.
- rd_data_vld  input  1  window valid.
- instr_finish  input  1  memory read pointer equals write pointer.
- shift_vld  output  1  one-cycle pulse: advance read pointer.
- read_pointer_shift_minusone  output  LOG_WINDOW+1  consumed length minus 1.
- instr_vld  output  1  decoded instruction valid.
- instr_rdy  input  1  execute stage accepts.
- opcode  output  8  opcode byte.
- imm  output  IMM_WIDTH  first immediate.
- imm_vld  output  1  opcode carries an immediate.
- instr_len  output  4  total bytes consumed.
- dec_err  output  1  sticky malformed-LEB flag.
- done  output  1  no more instructions; idle.

Behaviour:
- Reset (synchronous, rst=1 at posedge): every output is 0. State returns to IDLE and dec_err clears. An instruction held in OUT is discarded.
- IDLE:
  - instr_finish=1: done=1, stay in IDLE.
  - otherwise: go to FETCH.
- FETCH:
  - re=1 for this cycle.
  - If rd_data_vld=1: decode combinationally, register the results, go to OUT.
  - If rd_data_vld=0: stay in FETCH.
- OUT:
  - instr_vld=1, and opcode, imm, imm_vld, instr_len are held stable while waiting.
  - On instr_vld&instr_rdy: in that same cycle shift_vld=1 and read_pointer_shift_minusone=instr_len-1. The next cycle is IDLE.
  - Fetch-to-valid latency is 1 cycle. Throughput is 1 instruction per 3 cycles with instr_rdy held high.
- ERR:
  - Entered when the LEB runs to its 5th byte with the continuation bit set.
  - dec_err=1, instr_vld=0, no shift_vld. Only rst exits.
- Opcode classes:
  - Unsigned LEB immediate: 0x0c, 0x0d, 0x10, 0x20-0x24.
  - Signed LEB immediate: 0x41.
  - Single raw byte immediate (blocktype, imm = byte zero-extended): 0x02, 0x03, 0x04.
  - All other opcodes: no immediate, imm=0, imm_vld=0, len 1.
- LEB decode:
  - Byte n contributes bits [6:0] at position 7n. The last byte is the first byte with bit7=0. Maximum 5 bytes.
  - Signed: sign-extend from bit 7*len_leb-1 to IMM_WIDTH.
  - Bits above IMM_WIDTH are discarded.
- instr_finish asserting while in OUT: the held instruction is still delivered and shifted, then IDLE goes to done.
- A reset asserted in the same cycle as a handshake has priority; no shift_vld is issued.

Optional Feature:
- Macro: MEMARG_EN.
- Defined: opcodes 0x28-0x3e carry a memarg.
  - Byte 1 is align. It must be a single byte with bit7=0; otherwise go to ERR.
  - Followed by an unsigned LEB offset.
  - imm = offset, and an extra output align[7:0] is present.
  - instr_len = 2 + offset LEB length, maximum 7.
- Undefined: these opcodes decode as len 1 with no immediate, and the align port is absent.

Test Plan:
- Window 41 dd 01 ... -> opcode 0x41, imm 221 (0x000000DD), imm_vld 1, len 3, shift_minusone 2 on handshake.
- Window 41 7f -> imm 0xFFFFFFFF, len 2; window 20 01 -> local.get, imm 1, len 2.
- Window 6b, instr_rdy held low 5 cycles -> instr_vld and fields stable 5 cycles, no shift_vld; rdy=1 -> single shift_vld with shift_minusone 0.
- Window 20 80 80 80 80 80 -> dec_err=1 and stays set; no instr_vld; cleared only by rst.
- instr_finish=1 from reset -> done=1, re never asserted; rst mid-OUT -> instr_vld=0 next cycle, no shift.
- MEMARG_EN: window 28 02 10 -> opcode 0x28, align 2, imm 16, len 3; window 28 82 -> dec_err.
